// File: rtl/cov_mon_pkg.sv
// Shared types and helpers for the cmd x adr coverage monitor.
// Holds the sweep FSM state type, the bin index helper and the default widths.
package cov_mon_pkg;

    localparam int NCH_D    = 2;
    localparam int CMD_W_D  = 4;
    localparam int ADR_W_D  = 4;
    localparam int DATA_W_D = 4;
    localparam int CNT_W_D  = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } cov_state_e;

    // Cross bin index: cmd forms the upper bits, adr the lower bits.
    function automatic int unsigned bin_of(input int unsigned cmd,
                                           input int unsigned adr,
                                           input int unsigned adr_w);
        return (cmd << adr_w) | adr;
    endfunction

endpackage

// File: rtl/cov_mon_bin_inc.sv
// Combinational per-bin hit decode: for every cross bin, the number of channels
// hitting it this cycle (k) and whether this is the bin's first-ever hit.
module cov_mon_bin_inc
    import cov_mon_pkg::*;
#(
    parameter int NCH   = NCH_D,
    parameter int CMD_W = CMD_W_D,
    parameter int ADR_W = ADR_W_D,
    parameter int KW    = 2
) (
    input  logic [NCH-1:0]                    i_hit,
    input  logic [NCH*CMD_W-1:0]              i_cmd,
    input  logic [NCH*ADR_W-1:0]              i_adr,
    input  logic [(1<<(CMD_W+ADR_W))-1:0]     i_bitmap,
    output logic [(1<<(CMD_W+ADR_W))*KW-1:0]  o_k,
    output logic [(1<<(CMD_W+ADR_W))-1:0]     o_first
);

    localparam int NBIN = 1 << (CMD_W + ADR_W);

    genvar gi, gc;
    generate
        for (gi = 0; gi < NBIN; gi++) begin : g_bin
            logic [NCH-1:0] w_match;
            logic [KW-1:0]  w_k;

            for (gc = 0; gc < NCH; gc++) begin : g_ch
                assign w_match[gc] = i_hit[gc] &&
                    (bin_of(32'(i_cmd[gc*CMD_W +: CMD_W]),
                            32'(i_adr[gc*ADR_W +: ADR_W]),
                            32'(ADR_W)) == 32'(gi));
            end

            always_comb begin
                w_k = '0;
                for (int c = 0; c < NCH; c++) begin
                    w_k = w_k + KW'(w_match[c]);
                end
            end

            assign o_k[gi*KW +: KW] = w_k;
            assign o_first[gi]      = (w_k != '0) && !i_bitmap[gi];
        end
    endgenerate

endmodule

// File: rtl/cmd_adr_cov_mon.sv
// cmd x adr cross coverage monitor: saturating hit counter and hit bitmap per bin,
// read port, sweep clear FSM. Optional data toggle coverage: CMD_ADR_COV_MON_DATA_TGL_EN.
module cmd_adr_cov_mon
    import cov_mon_pkg::*;
#(
    parameter int NCH    = NCH_D,
    parameter int CMD_W  = CMD_W_D,
    parameter int ADR_W  = ADR_W_D,
    parameter int DATA_W = DATA_W_D,
    parameter int CNT_W  = CNT_W_D
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          ch_vld,
    input  logic [NCH*CMD_W-1:0]    ch_cmd,
    input  logic [NCH*ADR_W-1:0]    ch_adr,
    input  logic [NCH*DATA_W-1:0]   ch_data,
    input  logic                    enable,
    input  logic                    clr_req,
    output logic                    clr_busy,
    input  logic                    rd_req,
    input  logic [CMD_W+ADR_W-1:0]  rd_idx,
    output logic                    rd_vld,
    output logic [CNT_W-1:0]        rd_cnt,
    output logic                    rd_hit,
    output logic [CMD_W+ADR_W:0]    uniq_cnt,
    output logic                    sat_any,
    output logic [2*DATA_W-1:0]     tgl_cov
);

    localparam int IW   = CMD_W + ADR_W;
    localparam int NBIN = 1 << IW;
    localparam int KW   = $clog2(NCH + 1);
    localparam int SW   = CNT_W + KW;

    cov_state_e             r_state, w_state_next;
    logic [CMD_W-1:0]       r_row;
    logic [CNT_W-1:0]       r_cnt [NBIN];
    logic [NBIN-1:0]        r_bitmap;
    logic [IW:0]            r_uniq;
    logic                   r_sat;
    logic                   r_rd_vld;
    logic [CNT_W-1:0]       r_rd_cnt;
    logic                   r_rd_hit;
    logic [NCH-1:0]         w_hit;
    logic [NBIN*KW-1:0]     w_k;
    logic [NBIN-1:0]        w_first;
    logic [NBIN-1:0]        w_sat_set;
    logic [IW:0]            w_new;
    logic                   w_clearing;
    logic                   w_last_row;

    // A clear request in the same cycle as a hit takes precedence.
    assign w_hit = ch_vld & {NCH{enable && (r_state == IDLE) && !clr_req}};

    always_comb begin
        w_state_next = r_state;
        w_clearing   = 1'b0;
        w_last_row   = 1'b0;
        case (r_state)
            IDLE: begin
                if (clr_req) w_state_next = CLEAR;
            end
            CLEAR: begin
                w_clearing = 1'b1;
                if (r_row == '1) begin
                    w_last_row   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_row   <= '0;
        end else begin
            r_state <= w_state_next;
            r_row   <= w_clearing ? r_row + 1'b1 : '0;
        end
    end

    cov_mon_bin_inc #(
        .NCH   (NCH),
        .CMD_W (CMD_W),
        .ADR_W (ADR_W),
        .KW    (KW)
    ) u_bin_inc (
        .i_hit    (w_hit),
        .i_cmd    (ch_cmd),
        .i_adr    (ch_adr),
        .i_bitmap (r_bitmap),
        .o_k      (w_k),
        .o_first  (w_first)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NBIN; gi++) begin : g_cnt
            localparam logic [CMD_W-1:0] ROW  = CMD_W'(gi >> ADR_W);
            localparam logic [SW-1:0]    MAXV = {{KW{1'b0}}, {CNT_W{1'b1}}};
            logic [KW-1:0] w_kb;
            logic [SW-1:0] w_sum;

            assign w_kb  = w_k[gi*KW +: KW];
            assign w_sum = SW'(r_cnt[gi]) + SW'(w_kb);
            assign w_sat_set[gi] = (w_kb != '0) && (w_sum >= MAXV);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt[gi]    <= '0;
                    r_bitmap[gi] <= 1'b0;
                end else if (w_clearing && (r_row == ROW)) begin
                    r_cnt[gi]    <= '0;
                    r_bitmap[gi] <= 1'b0;
                end else if (w_kb != '0) begin
                    r_cnt[gi]    <= w_sat_set[gi] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
                    r_bitmap[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        w_new = '0;
        for (int i = 0; i < NBIN; i++) begin
            w_new = w_new + (IW+1)'(w_first[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_last_row) begin
            r_uniq <= '0;
            r_sat  <= 1'b0;
        end else begin
            r_uniq <= r_uniq + w_new;
            if (|w_sat_set) r_sat <= 1'b1;
        end
    end

    // Read returns the value registered before any hit landing this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld <= 1'b0;
            r_rd_cnt <= '0;
            r_rd_hit <= 1'b0;
        end else begin
            r_rd_vld <= rd_req;
            if (rd_req) begin
                r_rd_cnt <= r_cnt[rd_idx];
                r_rd_hit <= r_bitmap[rd_idx];
            end
        end
    end

`ifdef CMD_ADR_COV_MON_DATA_TGL_EN
    logic [2*DATA_W-1:0] r_tgl, w_tgl_set;

    always_comb begin
        w_tgl_set = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_hit[c]) begin
                w_tgl_set = w_tgl_set | {ch_data[c*DATA_W +: DATA_W], ~ch_data[c*DATA_W +: DATA_W]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_last_row) r_tgl <= '0;
        else                   r_tgl <= r_tgl | w_tgl_set;
    end

    assign tgl_cov = r_tgl;
`else
    logic w_unused_data;
    assign w_unused_data = ^ch_data;
    assign tgl_cov       = '0;
`endif

    assign clr_busy = (r_state == CLEAR);
    assign rd_vld   = r_rd_vld;
    assign rd_cnt   = r_rd_cnt;
    assign rd_hit   = r_rd_hit;
    assign uniq_cnt = r_uniq;
    assign sat_any  = r_sat;

endmodule

// File: tb/tb_cmd_adr_cov_mon.sv
// Directed bench for cmd_adr_cov_mon: a default instance plus a CNT_W=4 instance
// sharing the same stimulus, for the saturation cases.
module tb_cmd_adr_cov_mon;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ch_vld;
    logic [7:0]  ch_cmd;
    logic [7:0]  ch_adr;
    logic [7:0]  ch_data;
    logic        enable;
    logic        clr_req;
    logic        rd_req;
    logic [7:0]  rd_idx;

    logic        clr_busy, rd_vld, rd_hit, sat_any;
    logic [15:0] rd_cnt;
    logic [8:0]  uniq_cnt;
    logic [7:0]  tgl_cov;

    logic        s_clr_busy, s_rd_vld, s_rd_hit, s_sat_any;
    logic [3:0]  s_rd_cnt;
    logic [8:0]  s_uniq_cnt;
    logic [7:0]  s_tgl_cov;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cmd_adr_cov_mon dut (
        .clk(clk), .rst(rst), .ch_vld(ch_vld), .ch_cmd(ch_cmd), .ch_adr(ch_adr),
        .ch_data(ch_data), .enable(enable), .clr_req(clr_req), .clr_busy(clr_busy),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_vld(rd_vld), .rd_cnt(rd_cnt),
        .rd_hit(rd_hit), .uniq_cnt(uniq_cnt), .sat_any(sat_any), .tgl_cov(tgl_cov)
    );

    cmd_adr_cov_mon #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .ch_vld(ch_vld), .ch_cmd(ch_cmd), .ch_adr(ch_adr),
        .ch_data(ch_data), .enable(enable), .clr_req(clr_req), .clr_busy(s_clr_busy),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_vld(s_rd_vld), .rd_cnt(s_rd_cnt),
        .rd_hit(s_rd_hit), .uniq_cnt(s_uniq_cnt), .sat_any(s_sat_any), .tgl_cov(s_tgl_cov)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ch_vld = '0; ch_cmd = '0; ch_adr = '0; ch_data = '0;
        enable = 1'b1; clr_req = 1'b0; rd_req = 1'b0; rd_idx = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // One bus beat; byte b0/b1 = {cmd,adr} for channel 0/1.
    task automatic beat(input logic [1:0] vld, input logic [7:0] b0, input logic [7:0] b1);
        ch_vld = vld;
        ch_cmd = {b1[7:4], b0[7:4]};
        ch_adr = {b1[3:0], b0[3:0]};
        tick();
        ch_vld = '0;
    endtask

    task automatic do_read(input logic [7:0] idx);
        rd_req = 1'b1; rd_idx = idx;
        tick();
        rd_req = 1'b0;
        $display("read idx=%02h vld=%0b cnt=%0d hit=%0b uniq=%0d", idx, rd_vld, rd_cnt, rd_hit, uniq_cnt);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (rd_vld !== 1'b0)   begin n_err++; $display("FAIL reset_rd_vld got %0b exp 0", rd_vld); end
        n_cmp++; if (rd_cnt !== 16'd0)  begin n_err++; $display("FAIL reset_rd_cnt got %0d exp 0", rd_cnt); end
        n_cmp++; if (rd_hit !== 1'b0)   begin n_err++; $display("FAIL reset_rd_hit got %0b exp 0", rd_hit); end
        n_cmp++; if (uniq_cnt !== 9'd0) begin n_err++; $display("FAIL reset_uniq got %0d exp 0", uniq_cnt); end
        n_cmp++; if (sat_any !== 1'b0)  begin n_err++; $display("FAIL reset_sat got %0b exp 0", sat_any); end
        n_cmp++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b exp 0", clr_busy); end
        n_cmp++; if (tgl_cov !== 8'h00) begin n_err++; $display("FAIL reset_tgl got %02h exp 00", tgl_cov); end
    endtask

    task automatic test_single_hit();
        do_reset();
        beat(2'b01, 8'h35, 8'h00);
        do_read(8'h35);
        n_cmp++; if (rd_vld !== 1'b1)   begin n_err++; $display("FAIL single_vld got %0b exp 1", rd_vld); end
        n_cmp++; if (rd_cnt !== 16'd1)  begin n_err++; $display("FAIL single_cnt got %0d exp 1", rd_cnt); end
        n_cmp++; if (rd_hit !== 1'b1)   begin n_err++; $display("FAIL single_hit got %0b exp 1", rd_hit); end
        n_cmp++; if (uniq_cnt !== 9'd1) begin n_err++; $display("FAIL single_uniq got %0d exp 1", uniq_cnt); end
        tick();
        n_cmp++; if (rd_vld !== 1'b0)   begin n_err++; $display("FAIL single_vld_idle got %0b exp 0", rd_vld); end
        enable = 1'b0;
        beat(2'b11, 8'h35, 8'h36);
        enable = 1'b1;
        do_read(8'h35);
        n_cmp++; if (rd_cnt !== 16'd1)  begin n_err++; $display("FAIL disabled_cnt got %0d exp 1", rd_cnt); end
        n_cmp++; if (uniq_cnt !== 9'd1) begin n_err++; $display("FAIL disabled_uniq got %0d exp 1", uniq_cnt); end
    endtask

    task automatic test_same_bin();
        do_reset();
        for (int i = 0; i < 3; i++) beat(2'b11, 8'h11, 8'h11);
        do_read(8'h11);
        n_cmp++; if (rd_cnt !== 16'd6)  begin n_err++; $display("FAIL same_bin_cnt got %0d exp 6", rd_cnt); end
        n_cmp++; if (uniq_cnt !== 9'd1) begin n_err++; $display("FAIL same_bin_uniq got %0d exp 1", uniq_cnt); end
        beat(2'b11, 8'h22, 8'h23);
        do_read(8'h23);
        n_cmp++; if (rd_cnt !== 16'd1)  begin n_err++; $display("FAIL two_bin_cnt got %0d exp 1", rd_cnt); end
        n_cmp++; if (uniq_cnt !== 9'd3) begin n_err++; $display("FAIL two_bin_uniq got %0d exp 3", uniq_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 14; i++) beat(2'b01, 8'h00, 8'h00);
        do_read(8'h00);
        n_cmp++; if (s_rd_cnt !== 4'd14) begin n_err++; $display("FAIL sat14_cnt got %0d exp 14", s_rd_cnt); end
        n_cmp++; if (s_sat_any !== 1'b0) begin n_err++; $display("FAIL sat14_flag got %0b exp 0", s_sat_any); end
        for (int i = 0; i < 6; i++) beat(2'b01, 8'h00, 8'h00);
        do_read(8'h00);
        n_cmp++; if (s_rd_cnt !== 4'd15) begin n_err++; $display("FAIL sat20_cnt got %0d exp 15", s_rd_cnt); end
        n_cmp++; if (s_sat_any !== 1'b1) begin n_err++; $display("FAIL sat20_flag got %0b exp 1", s_sat_any); end
        n_cmp++; if (rd_cnt !== 16'd20)  begin n_err++; $display("FAIL wide20_cnt got %0d exp 20", rd_cnt); end
        n_cmp++; if (sat_any !== 1'b0)   begin n_err++; $display("FAIL wide20_flag got %0b exp 0", sat_any); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        beat(2'b01, 8'h12, 8'h00);
        ch_vld = 2'b01; ch_cmd = 8'h01; ch_adr = 8'h02;
        rd_req = 1'b1; rd_idx = 8'h12;
        tick();
        ch_vld = '0; rd_req = 1'b0;
        n_cmp++; if (rd_cnt !== 16'd1) begin n_err++; $display("FAIL b2b_old_cnt got %0d exp 1", rd_cnt); end
        do_read(8'h12);
        n_cmp++; if (rd_cnt !== 16'd2) begin n_err++; $display("FAIL b2b_new_cnt got %0d exp 2", rd_cnt); end
    endtask

    task automatic test_clear();
        int busy;
        logic [7:0] idx;
        do_reset();
        for (int i = 0; i < 5; i++) beat(2'b11, {4'(i), 4'(i)}, {4'(i + 8), 4'(i)});
        n_cmp++; if (uniq_cnt !== 9'd10) begin n_err++; $display("FAIL fill_uniq got %0d exp 10", uniq_cnt); end
        clr_req = 1'b1;
        beat(2'b01, 8'h77, 8'h00);
        clr_req = 1'b0;
        busy = 0;
        for (int c = 0; c < 40; c++) begin
            if (!clr_busy) break;
            busy++;
            ch_vld = 2'b11; ch_cmd = 8'h55; ch_adr = 8'h55;
            clr_req = (busy == 6);
            if (busy == 3) begin rd_req = 1'b1; rd_idx = 8'h00; end
            if (busy == 4) begin
                n_cmp++; if (rd_cnt !== 16'd0) begin n_err++; $display("FAIL sweep_done_row got %0d exp 0", rd_cnt); end
                rd_idx = 8'h80;
            end
            if (busy == 5) begin
                n_cmp++; if (rd_cnt !== 16'd1) begin n_err++; $display("FAIL sweep_pending_row got %0d exp 1", rd_cnt); end
                rd_req = 1'b0;
            end
            tick();
        end
        ch_vld = '0; clr_req = 1'b0; rd_req = 1'b0;
        $display("sweep busy cycles=%0d", busy);
        n_cmp++; if (busy !== 16)        begin n_err++; $display("FAIL clr_busy_len got %0d exp 16", busy); end
        n_cmp++; if (clr_busy !== 1'b0)  begin n_err++; $display("FAIL clr_busy_end got %0b exp 0", clr_busy); end
        n_cmp++; if (uniq_cnt !== 9'd0)  begin n_err++; $display("FAIL clear_uniq got %0d exp 0", uniq_cnt); end
        for (int i = 0; i < 12; i++) begin
            idx = (i < 5) ? {4'(i), 4'(i)} : (i < 10) ? {4'(i + 3), 4'(i - 5)} : (i == 10) ? 8'h77 : 8'h55;
            do_read(idx);
            n_cmp++; if (rd_cnt !== 16'd0 || rd_hit !== 1'b0)
                begin n_err++; $display("FAIL clear_bin_%02h got cnt=%0d hit=%0b exp 0/0", idx, rd_cnt, rd_hit); end
        end
        beat(2'b01, 8'h35, 8'h00);
        tick();
        n_cmp++; if (uniq_cnt !== 9'd1) begin n_err++; $display("FAIL post_clear_uniq got %0d exp 1", uniq_cnt); end
    endtask

    task automatic test_reset_mid_sweep();
        do_reset();
        beat(2'b01, 8'hF0, 8'h00);
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %0b exp 0", clr_busy); end
        n_cmp++; if (uniq_cnt !== 9'd0) begin n_err++; $display("FAIL midrst_uniq got %0d exp 0", uniq_cnt); end
        do_read(8'hF0);
        n_cmp++; if (rd_cnt !== 16'd0)  begin n_err++; $display("FAIL midrst_cnt got %0d exp 0", rd_cnt); end
    endtask

    task automatic test_toggle();
        logic [7:0] exp1, exp2;
`ifdef CMD_ADR_COV_MON_DATA_TGL_EN
        exp1 = 8'h5A; exp2 = 8'hFF;
`else
        exp1 = 8'h00; exp2 = 8'h00;
`endif
        do_reset();
        ch_data = 8'h05;
        beat(2'b01, 8'h01, 8'h00);
        n_cmp++; if (tgl_cov !== exp1) begin n_err++; $display("FAIL tgl_first got %02h exp %02h", tgl_cov, exp1); end
        ch_data = 8'h0A;
        beat(2'b01, 8'h01, 8'h00);
        n_cmp++; if (tgl_cov !== exp2) begin n_err++; $display("FAIL tgl_both got %02h exp %02h", tgl_cov, exp2); end
        ch_data = 8'h00;
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_same_bin();
        test_saturate();
        test_back_to_back();
        test_clear();
        test_reset_mid_sweep();
        test_toggle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
